// File: rtl/dbuf_bank_sched.sv
// Ping-pong bank scheduler for a two-bank write double buffer.
// Grants empty banks to the fill side, tracks occupancy per bank, and presents
// full banks to the drain side in the order their fills completed.
module dbuf_bank_sched #(
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             fill_req_i,
    input  logic [LEN_W-1:0] fill_len_i,
    output logic             fill_gnt_o,
    output logic             fill_bank_o,
    input  logic             fill_beat_i,
    output logic             fill_last_o,
    output logic             drain_valid_o,
    input  logic             drain_ready_i,
    output logic             drain_bank_o,
    output logic [LEN_W-1:0] drain_len_o,
    input  logic             drain_beat_i,
    output logic             drain_last_o,
    output logic [1:0]       bank_full_o,
    output logic             err_o
);

    typedef enum logic [1:0] {
        B_EMPTY,
        B_FILLING,
        B_FULL,
        B_DRAINING
    } bank_state_t;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } side_t;

    bank_state_t      bank_q [2];
    bank_state_t      bank_d [2];
    logic [LEN_W-1:0] len_q  [2];
    logic [LEN_W-1:0] len_d  [2];

    side_t            fill_st_q, fill_st_d;
    side_t            drain_st_q, drain_st_d;
    logic             fill_bank_q, fill_bank_d;
    logic [LEN_W-1:0] fill_cnt_q, fill_cnt_d;
    logic [LEN_W-1:0] drain_cnt_q, drain_cnt_d;

    // Drain order: a two-entry queue of bank indices in fill-completion order.
    // Entry 0 is the oldest full bank.
    logic             ord_q [2];
    logic             ord_d [2];
    logic [1:0]       ord_cnt_q, ord_cnt_d;

    logic             err_q, err_d;

    logic             any_empty;
    logic             free_idx;
    logic             push_ord;
    logic             pop_ord;

    // Output decode from registered state
    always_comb begin
        any_empty     = (bank_q[0] == B_EMPTY) || (bank_q[1] == B_EMPTY);
        free_idx      = (bank_q[0] != B_EMPTY);
        fill_gnt_o    = rst_n_i && (fill_st_q == S_IDLE) && any_empty;
        fill_bank_o   = (fill_st_q == S_IDLE) ? free_idx : fill_bank_q;
        fill_last_o   = (fill_st_q == S_BUSY) && fill_beat_i &&
                        (fill_cnt_q == len_q[fill_bank_q]);
        drain_bank_o  = ord_q[0];
        drain_len_o   = len_q[ord_q[0]];
        drain_valid_o = (drain_st_q == S_IDLE) && (ord_cnt_q != 2'd0) &&
                        (bank_q[ord_q[0]] == B_FULL);
        drain_last_o  = (drain_st_q == S_BUSY) && drain_beat_i &&
                        (drain_cnt_q == len_q[ord_q[0]]);
        bank_full_o[0] = (bank_q[0] == B_FULL) || (bank_q[0] == B_DRAINING);
        bank_full_o[1] = (bank_q[1] == B_FULL) || (bank_q[1] == B_DRAINING);
        err_o         = err_q;
    end

    // Next-state for both side FSMs, bank states, counters and drain order
    always_comb begin
        bank_d      = bank_q;
        len_d       = len_q;
        fill_st_d   = fill_st_q;
        drain_st_d  = drain_st_q;
        fill_bank_d = fill_bank_q;
        fill_cnt_d  = fill_cnt_q;
        drain_cnt_d = drain_cnt_q;
        ord_d       = ord_q;
        ord_cnt_d   = ord_cnt_q;
        err_d       = 1'b0;
        push_ord    = 1'b0;
        pop_ord     = 1'b0;

        case (fill_st_q)
            S_IDLE: begin
                if (fill_beat_i) begin
                    err_d = 1'b1;
                end
                if (fill_req_i && fill_gnt_o) begin
                    bank_d[free_idx] = B_FILLING;
                    len_d[free_idx]  = fill_len_i;
                    fill_bank_d      = free_idx;
                    fill_cnt_d       = '0;
                    fill_st_d        = S_BUSY;
                end
            end
            S_BUSY: begin
                if (fill_beat_i) begin
                    if (fill_last_o) begin
                        bank_d[fill_bank_q] = B_FULL;
                        fill_st_d           = S_IDLE;
                        push_ord            = 1'b1;
                    end else begin
                        fill_cnt_d = fill_cnt_q + LEN_W'(1);
                    end
                end
            end
            default: fill_st_d = S_IDLE;
        endcase

        case (drain_st_q)
            S_IDLE: begin
                if (drain_beat_i) begin
                    err_d = 1'b1;
                end
                if (drain_valid_o && drain_ready_i) begin
                    bank_d[ord_q[0]] = B_DRAINING;
                    drain_cnt_d      = '0;
                    drain_st_d       = S_BUSY;
                end
            end
            S_BUSY: begin
                if (drain_beat_i) begin
                    if (drain_last_o) begin
                        bank_d[ord_q[0]] = B_EMPTY;
                        drain_st_d       = S_IDLE;
                        pop_ord          = 1'b1;
                    end else begin
                        drain_cnt_d = drain_cnt_q + LEN_W'(1);
                    end
                end
            end
            default: drain_st_d = S_IDLE;
        endcase

        // Pop before push so a drain completing alongside a fill completing
        // leaves the newly full bank at the correct queue position.
        if (pop_ord) begin
            ord_d[0]  = ord_q[1];
            ord_cnt_d = ord_cnt_q - 2'd1;
        end
        if (push_ord) begin
            ord_d[ord_cnt_d[0]] = fill_bank_q;
            ord_cnt_d           = ord_cnt_d + 2'd1;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bank_q[0]   <= B_EMPTY;
            bank_q[1]   <= B_EMPTY;
            len_q[0]    <= '0;
            len_q[1]    <= '0;
            fill_st_q   <= S_IDLE;
            drain_st_q  <= S_IDLE;
            fill_bank_q <= 1'b0;
            fill_cnt_q  <= '0;
            drain_cnt_q <= '0;
            ord_q[0]    <= 1'b0;
            ord_q[1]    <= 1'b0;
            ord_cnt_q   <= 2'd0;
            err_q       <= 1'b0;
        end else begin
            bank_q      <= bank_d;
            len_q       <= len_d;
            fill_st_q   <= fill_st_d;
            drain_st_q  <= drain_st_d;
            fill_bank_q <= fill_bank_d;
            fill_cnt_q  <= fill_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            ord_q       <= ord_d;
            ord_cnt_q   <= ord_cnt_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_dbuf_bank_sched.sv
// Scoreboard bench for dbuf_bank_sched: stimulus pushes expected grants,
// drain offers, last-beat positions and error pulses; a monitor pops them.
module tb_dbuf_bank_sched;

    localparam int unsigned LW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fill_req;
    logic [LW-1:0] fill_len;
    logic          fill_gnt_o;
    logic          fill_bank_o;
    logic          fill_beat;
    logic          fill_last_o;
    logic          drain_valid_o;
    logic          drain_ready;
    logic          drain_bank_o;
    logic [LW-1:0] drain_len_o;
    logic          drain_beat;
    logic          drain_last_o;
    logic [1:0]    bank_full_o;
    logic          err_o;

    dbuf_bank_sched #(.LEN_W(LW)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .fill_req_i    (fill_req),
        .fill_len_i    (fill_len),
        .fill_gnt_o    (fill_gnt_o),
        .fill_bank_o   (fill_bank_o),
        .fill_beat_i   (fill_beat),
        .fill_last_o   (fill_last_o),
        .drain_valid_o (drain_valid_o),
        .drain_ready_i (drain_ready),
        .drain_bank_o  (drain_bank_o),
        .drain_len_o   (drain_len_o),
        .drain_beat_i  (drain_beat),
        .drain_last_o  (drain_last_o),
        .bank_full_o   (bank_full_o),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int q_gnt[$];    // expected fill_bank_o at each fill handshake
    int q_fl[$];     // expected beat number carrying fill_last_o
    int q_dbank[$];  // expected drain_bank_o at each drain handshake
    int q_dlen[$];   // expected drain_len_o at each drain handshake
    int q_dl[$];     // expected beat number carrying drain_last_o
    int q_err[$];    // expected bank_full_o while err_o pulses

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic miss(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event without matching expectation or timed out", nm);
    endtask

    // Monitor: compares DUT events against the scoreboard queues
    int fcnt = 0;
    int dcnt = 0;
    bit in_fill = 0;
    bit in_drain = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            fcnt = 0; dcnt = 0; in_fill = 0; in_drain = 0;
        end else begin
            if (fill_last_o) begin
                if (q_fl.size() == 0) miss("fill_last_unexpected");
                else chk("fill_last_beat", fcnt + 1, q_fl.pop_front());
                in_fill = 0; fcnt = 0;
            end else if (fill_beat && in_fill) begin
                fcnt++;
            end
            if (fill_req && fill_gnt_o) begin
                if (q_gnt.size() == 0) miss("fill_gnt_unexpected");
                else chk("fill_gnt_bank", int'(fill_bank_o), q_gnt.pop_front());
                in_fill = 1; fcnt = 0;
            end
            if (drain_last_o) begin
                if (q_dl.size() == 0) miss("drain_last_unexpected");
                else chk("drain_last_beat", dcnt + 1, q_dl.pop_front());
                in_drain = 0; dcnt = 0;
            end else if (drain_beat && in_drain) begin
                dcnt++;
            end
            if (drain_valid_o && drain_ready) begin
                if (q_dbank.size() == 0 || q_dlen.size() == 0) miss("drain_hs_unexpected");
                else begin
                    chk("drain_bank", int'(drain_bank_o), q_dbank.pop_front());
                    chk("drain_len", int'(drain_len_o), q_dlen.pop_front());
                end
                in_drain = 1; dcnt = 0;
            end
            if (err_o) begin
                if (q_err.size() == 0) miss("err_unexpected");
                else chk("err_bank_full", int'(bank_full_o), q_err.pop_front());
            end
        end
    end

    task automatic do_fill(input int len, input int exp_bank);
        int t;
        q_gnt.push_back(exp_bank);
        q_fl.push_back(len + 1);
        fill_len = LW'(len);
        fill_req = 1'b1;
        t = 0;
        @(negedge clk);
        while (!fill_gnt_o && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!fill_gnt_o) miss("fill_gnt_timeout");
        @(posedge clk); #1;
        fill_req = 1'b0;
        for (int i = 0; i <= len; i++) begin
            fill_beat = 1'b1;
            @(posedge clk); #1;
        end
        fill_beat = 1'b0;
    endtask

    task automatic do_drain(input int len, input int exp_bank);
        int t;
        q_dbank.push_back(exp_bank);
        q_dlen.push_back(len);
        q_dl.push_back(len + 1);
        drain_ready = 1'b1;
        t = 0;
        @(negedge clk);
        while (!drain_valid_o && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!drain_valid_o) miss("drain_valid_timeout");
        @(posedge clk); #1;
        drain_ready = 1'b0;
        for (int i = 0; i <= len; i++) begin
            drain_beat = 1'b1;
            @(posedge clk); #1;
        end
        drain_beat = 1'b0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_gnt"}, int'(fill_gnt_o), 0);
        chk({tag, "_dvalid"}, int'(drain_valid_o), 0);
        chk({tag, "_full"}, int'(bank_full_o), 0);
        chk({tag, "_err"}, int'(err_o), 0);
        chk({tag, "_fbank"}, int'(fill_bank_o), 0);
        chk({tag, "_dbank"}, int'(drain_bank_o), 0);
        chk({tag, "_dlen"}, int'(drain_len_o), 0);
        chk({tag, "_flast"}, int'(fill_last_o), 0);
        chk({tag, "_dlast"}, int'(drain_last_o), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        fill_req = 1'b0; fill_len = '0; fill_beat = 1'b0;
        drain_ready = 1'b0; drain_beat = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outs("rst");
        rst_n = 1'b1;
        #1;
        chk("post_rst_gnt", int'(fill_gnt_o), 1);
        @(posedge clk); #1;

        // Single burst, len 3
        do_fill(3, 0);
        chk("single_dvalid", int'(drain_valid_o), 1);
        chk("single_full", int'(bank_full_o), 1);
        chk("single_dlen", int'(drain_len_o), 3);
        do_drain(3, 0);
        chk("single_empty", int'(bank_full_o), 0);

        // Ping-pong, four len-7 bursts with concurrent drain
        fork
            begin
                do_fill(7, 0); do_fill(7, 1); do_fill(7, 0); do_fill(7, 1);
            end
            begin
                do_drain(7, 0); do_drain(7, 1); do_drain(7, 0); do_drain(7, 1);
            end
        join
        @(posedge clk); #1;
        chk("pp_empty", int'(bank_full_o), 0);

        // Backpressure: both banks full, requester stalls
        do_fill(0, 0);
        do_fill(0, 1);
        fill_len = LW'(5);
        fill_req = 1'b1;
        q_gnt.push_back(0);
        q_fl.push_back(6);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_gnt_low", int'(fill_gnt_o), 0);
            chk("bp_full", int'(bank_full_o), 3);
        end
        chk("bp_oldest", int'(drain_bank_o), 0);
        q_dbank.push_back(0); q_dlen.push_back(0); q_dl.push_back(1);
        @(posedge clk); #1;
        drain_ready = 1'b1;
        @(posedge clk); #1;
        drain_ready = 1'b0;
        drain_beat = 1'b1;
        @(negedge clk);
        chk("bp_dlast", int'(drain_last_o), 1);
        chk("bp_gnt_same_cycle", int'(fill_gnt_o), 0);
        @(posedge clk); #1;
        drain_beat = 1'b0;
        @(negedge clk);
        chk("bp_gnt_next", int'(fill_gnt_o), 1);
        chk("bp_gnt_bank", int'(fill_bank_o), 0);
        @(posedge clk); #1;
        fill_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            fill_beat = 1'b1;
            @(posedge clk); #1;
        end
        fill_beat = 1'b0;
        do_drain(0, 1);
        do_drain(5, 0);

        // Length edges
        do_fill(0, 0);
        chk("len0_dlen", int'(drain_len_o), 0);
        do_drain(0, 0);
        do_fill(255, 0);
        chk("len255_dlen", int'(drain_len_o), 255);
        do_drain(255, 0);

        // Protocol errors
        q_err.push_back(0);
        fill_beat = 1'b1;
        @(posedge clk); #1;
        fill_beat = 1'b0;
        @(negedge clk);
        chk("err_fill_pulse", int'(err_o), 1);
        @(negedge clk);
        chk("err_fill_width", int'(err_o), 0);
        chk("err_fill_gnt", int'(fill_gnt_o), 1);
        @(posedge clk); #1;
        q_err.push_back(0);
        drain_beat = 1'b1;
        @(posedge clk); #1;
        drain_beat = 1'b0;
        @(negedge clk);
        chk("err_drain_pulse", int'(err_o), 1);
        @(negedge clk);
        chk("err_drain_width", int'(err_o), 0);
        @(posedge clk); #1;
        // drain-side violation in the middle of a fill must not disturb it
        q_gnt.push_back(0); q_fl.push_back(3);
        fill_len = LW'(2);
        fill_req = 1'b1;
        @(posedge clk); #1;
        fill_req = 1'b0;
        fill_beat = 1'b1;
        @(posedge clk); #1;
        fill_beat = 1'b0;
        q_err.push_back(0);
        drain_beat = 1'b1;
        @(posedge clk); #1;
        drain_beat = 1'b0;
        fill_beat = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        fill_beat = 1'b0;
        chk("err_mid_full", int'(bank_full_o), 1);
        do_drain(2, 0);

        // Async reset mid-fill
        q_gnt.push_back(0);
        fill_len = LW'(3);
        fill_req = 1'b1;
        @(posedge clk); #1;
        fill_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            fill_beat = 1'b1;
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outs("rst_fill");
        fill_beat = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("rst_fill_regnt", int'(fill_gnt_o), 1);
        chk("rst_fill_rebank", int'(fill_bank_o), 0);
        @(posedge clk); #1;

        // Async reset mid-drain of bank 1
        do_fill(1, 0);
        do_fill(2, 1);
        do_drain(1, 0);
        q_dbank.push_back(1); q_dlen.push_back(2);
        drain_ready = 1'b1;
        @(posedge clk); #1;
        drain_ready = 1'b0;
        drain_beat = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outs("rst_drain");
        drain_beat = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_fill(0, 0);
        do_drain(0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("left_gnt", q_gnt.size(), 0);
        chk("left_fl", q_fl.size(), 0);
        chk("left_dbank", q_dbank.size(), 0);
        chk("left_dl", q_dl.size(), 0);
        chk("left_err", q_err.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dbuf_bank_sched.md
Name: dbuf_bank_sched

Overview:
Ping-pong bank scheduler for the two-bank write double buffer. It hands an empty bank to the AXI write-fill side per burst and counts fill beats to mark the bank full. It then presents full banks to the downstream drain consumer, strictly in fill-completion order. It owns bank occupancy state; the bank datapaths only follow its grants.

Parameters:
LEN_W, 8, width of burst length fields (AXI awlen style, value = beats-1)

Ports:
clk_i  in  1  clock, all logic rising-edge
rst_n_i  in  1  reset, asynchronous, active-low
fill_req_i  in  1  fill side requests a bank for a new burst
fill_len_i  in  LEN_W  beats-1 of requested burst, sampled on fill handshake
fill_gnt_o  out  1  bank granted; handshake = fill_req_i & fill_gnt_o
fill_bank_o  out  1  index of bank currently being filled
fill_beat_i  in  1  one beat written into fill_bank_o this cycle
fill_last_o  out  1  current fill beat is final beat of burst (combinational)
drain_valid_o  out  1  oldest full bank ready to drain
drain_ready_i  in  1  consumer accepts drain; handshake = valid & ready
drain_bank_o  out  1  index of bank offered/being drained
drain_len_o  out  LEN_W  stored beats-1 of drain_bank_o
drain_beat_i  in  1  consumer consumed one beat of drain_bank_o
drain_last_o  out  1  current drain beat is final beat (combinational)
bank_full_o  out  2  per-bank FULL-or-DRAINING flag
err_o  out  1  one-cycle pulse on protocol violation

Behaviour:
- Reset: all banks EMPTY, both sides IDLE, counters 0, oldest pointer 0; fill_gnt_o=0 during reset; drain_valid_o=0, bank_full_o=2'b00, err_o=0, fill_bank_o=0, drain_bank_o=0, drain_len_o=0. Async reset mid-burst discards all state immediately.
- Per-bank state: EMPTY -> FILLING (fill handshake) -> FULL (last fill beat) -> DRAINING (drain handshake) -> EMPTY (last drain beat). A stored length register per bank.
- Fill side FSM IDLE/BUSY. fill_gnt_o = IDLE & (any bank EMPTY), combinational from registered state. Bank chosen = lowest-index EMPTY bank. On handshake: bank -> FILLING, fill_len_i stored, beat counter cleared, side -> BUSY.
- In BUSY each fill_beat_i increments counter; fill_last_o = BUSY & fill_beat_i & (count == len). On that beat bank -> FULL, side -> IDLE next cycle; bank appended to drain order. Next grant possible the cycle after last beat (one idle cycle minimum, no same-cycle re-grant).
- Drain side FSM IDLE/BUSY. drain_valid_o = IDLE & bank[oldest]==FULL, registered-state derived; drain_bank_o = oldest. Valid stays high until accepted (no withdrawal). On handshake bank -> DRAINING, side -> BUSY.
- drain_last_o = BUSY & drain_beat_i & (count == drain_len_o). On it bank -> EMPTY, oldest pointer toggles, side -> IDLE.
- Ordering: banks drain in fill-completion order; with two banks this is strict alternation after the first.
- Simultaneous events: drain-last freeing bank X and fill_req_i same cycle -> X not grantable until next cycle. Fill-last on bank X -> drain_valid_o for X earliest next cycle. Fill and drain on different banks proceed fully concurrently.
- Both banks not EMPTY -> fill_gnt_o=0, requester stalls (backpressure, not error).
- err_o pulses (1 cycle, no state change) for: fill_beat_i while fill IDLE; drain_beat_i while drain IDLE. Offending beat is ignored.
- len=0 burst: single beat is both first and last.
- Counters LEN_W bits, never exceed stored len, no wrap.

Test Plan:
- Single burst: reset, fill_req len=3, 4 fill beats -> gnt on cycle 1 bank 0, fill_last_o on beat 4, next cycle drain_valid_o=1 bank 0 len 3; 4 drain beats -> drain_last_o on 4th, bank_full_o back to 00.
- Ping-pong: fill len=7 into bank 0, immediately fill len=7 -> bank 1 granted while bank 0 drains; drain order 0,1,0,1 over 4 bursts; no err_o.
- Backpressure: fill two bursts, hold drain_ready_i=0 -> fill_gnt_o=0 with fill_req_i high, bank_full_o=11; release ready for one drain completion -> gnt reappears cycle after drain_last_o, bank 0.
- Length edge: len=0 and len=255 bursts -> last asserted on beat 1 and beat 256 respectively; drain_len_o=0/255.
- Protocol errors: fill_beat_i with no grant, drain_beat_i with drain IDLE -> err_o single-cycle pulse each, counters and bank_full_o unchanged.
- Async reset mid-fill (bank 0 at beat 2 of 4) and mid-drain -> all outputs return to reset values immediately, fresh fill grants bank 0.
